// File: rtl/qos_pkg.sv
// rtl/qos_pkg.sv - shared FSM encoding, default parameters and search helper for qos_wrr
package qos_pkg;

    localparam int DEF_NUM_VC   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_WEIGHT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_SERVE = 2'd2
    } qos_state_t;

    // Cyclic successor used by the round-robin search.
    function automatic int wrap_add(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/qos_vc_fifo.sv
// rtl/qos_vc_fifo.sv - show-ahead per-VC FIFO with occupancy count
module qos_vc_fifo
    import qos_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enb,
    input  logic                   push,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Fullness uses the pre-edge count: a push to a full FIFO is dropped even if a pop frees a slot this cycle.
    assign do_push = enb && push && !full;
    assign do_pop  = enb && pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/qos_wrr.sv
// rtl/qos_wrr.sv - weighted round-robin VC scheduler; define QOS_DROP_CNT_EN for per-VC drop counters
module qos_wrr
    import qos_pkg::*;
#(
    parameter int NUM_VC   = DEF_NUM_VC,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int WEIGHT_W = DEF_WEIGHT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_VC)-1:0]  vc_id,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [$clog2(DEPTH):0]     umbral_max,
    input  logic [$clog2(DEPTH):0]     umbral_min,
    input  logic [NUM_VC*WEIGHT_W-1:0] mem_pesos,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_VC)-1:0]  out_vc,
    output logic [NUM_VC-1:0]          pausa,
    output logic [NUM_VC-1:0]          continuar,
    output logic [NUM_VC-1:0]          error_full,
    output logic                       idle
`ifdef QOS_DROP_CNT_EN
    ,
    output logic [NUM_VC*8-1:0]        drop_cnt
`endif
);
    localparam int VC_W = $clog2(NUM_VC);
    localparam int CW   = $clog2(DEPTH) + 1;

    qos_state_t                    state;
    logic [WEIGHT_W-1:0]           credit;
    logic [VC_W-1:0]               last_vc;
    logic [VC_W-1:0]               pick;
    logic [WEIGHT_W-1:0]           pick_weight;
    logic                          found;
    logic                          pop_now;
    logic [NUM_VC-1:0]             full;
    logic [NUM_VC-1:0]             empty;
    logic [NUM_VC-1:0]             eligible;
    logic [NUM_VC-1:0]             paused;
    logic [NUM_VC-1:0][DATA_W-1:0] head;
    logic [NUM_VC-1:0][CW-1:0]     occ;

    assign pop_now = out_valid && out_ready;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        qos_vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .enb     (enb),
            .push    (wr_en && (vc_id == VC_W'(v))),
            .wr_data (data_in),
            .pop     (pop_now && (out_vc == VC_W'(v))),
            .head    (head[v]),
            .count   (occ[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );
        assign eligible[v] = !empty[v] && (mem_pesos[v*WEIGHT_W +: WEIGHT_W] != '0);
    end

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            if (!found && eligible[wrap_add(int'(last_vc), i, NUM_VC)]) begin
                found = 1'b1;
                pick  = VC_W'(wrap_add(int'(last_vc), i, NUM_VC));
            end
        end
    end

    assign pick_weight = mem_pesos[int'(pick)*WEIGHT_W +: WEIGHT_W];
    assign out_data    = out_valid ? head[out_vc] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            last_vc   <= VC_W'(NUM_VC - 1);
            credit    <= '0;
            out_valid <= 1'b0;
            out_vc    <= '0;
            idle      <= 1'b1;
        end else if (enb) begin
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        state <= ST_ARB;
                        idle  <= 1'b0;
                    end
                end
                ST_ARB: begin
                    if (found) begin
                        state     <= ST_SERVE;
                        out_vc    <= pick;
                        credit    <= pick_weight;
                        out_valid <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        idle  <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (out_ready) begin
                        credit <= credit - 1'b1;
                        // The run ends when this pop spends the last credit or takes the last word.
                        if (credit == WEIGHT_W'(1) || occ[out_vc] == CW'(1)) begin
                            state     <= ST_ARB;
                            out_valid <= 1'b0;
                            last_vc   <= out_vc;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    idle      <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paused     <= '0;
            pausa      <= '0;
            continuar  <= '0;
            error_full <= '0;
        end else if (!enb) begin
            pausa      <= '0;
            continuar  <= '0;
            error_full <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                pausa[v]      <= 1'b0;
                continuar[v]  <= 1'b0;
                error_full[v] <= wr_en && (vc_id == VC_W'(v)) && full[v];
                // Resume is only considered while paused, so the two pulses can never coincide.
                if (paused[v] && occ[v] <= umbral_min) begin
                    continuar[v] <= 1'b1;
                    paused[v]    <= 1'b0;
                end else if (!paused[v] && occ[v] >= umbral_max) begin
                    pausa[v]  <= 1'b1;
                    paused[v] <= 1'b1;
                end
            end
        end
    end

`ifdef QOS_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (enb && wr_en && full[vc_id] && drop_cnt[int'(vc_id)*8 +: 8] != 8'hFF) begin
            drop_cnt[int'(vc_id)*8 +: 8] <= drop_cnt[int'(vc_id)*8 +: 8] + 8'd1;
        end
    end
`endif

endmodule
